instr_encoder: RTL

Instruction encoder and issue buffer for the MIPS pipeline. It accepts symbolic instruction commands (mnemonic code plus register, immediate and target fields) and packs them into 32-bit MIPS instruction words. It pads load-use hazards and optional branch delay slots with NOPs, and streams the result through a small FIFO to the instruction-memory loader / self-test fetch path. It produces exactly the op/func encodings that the pipeline controller decodes.

---
 rtl/instr_encoder.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS commands into 32-bit words, pads load-use hazards and branch delay slots with NOPs.
// Latency: word visible one cycle after the accepting edge, plus one cycle per inserted NOP.
// Backpressure: cmd_ready only in IDLE; every FIFO push stalls the FSM while the FIFO is full.
module instr_encoder #(
  parameter int DEPTH         = 4,
  parameter int LOAD_USE_NOPS = 1,
  parameter int BRANCH_NOPS   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_mnem,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  input  logic [25:0] cmd_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_illegal,
  output logic [15:0] instr_count
);

  localparam logic [3:0] M_ADDU = 4'd0;
  localparam logic [3:0] M_SUBU = 4'd1;
  localparam logic [3:0] M_ORI  = 4'd2;
  localparam logic [3:0] M_LW   = 4'd3;
  localparam logic [3:0] M_SW   = 4'd4;
  localparam logic [3:0] M_BEQ  = 4'd5;
  localparam logic [3:0] M_LUI  = 4'd6;
  localparam logic [3:0] M_ADDI = 4'd7;
  localparam logic [3:0] M_SLT  = 4'd8;
  localparam logic [3:0] M_J    = 4'd9;
  localparam logic [3:0] M_JAL  = 4'd10;
  localparam logic [3:0] M_JR   = 4'd11;

  localparam int         AW     = $clog2(DEPTH);
  localparam int         CW     = AW + 1;
  localparam logic [7:0] LU_N   = 8'(LOAD_USE_NOPS);
  localparam logic [7:0] BR_N   = 8'(BRANCH_NOPS);
  localparam bit         USE_LU = (LOAD_USE_NOPS > 0);
  localparam bit         USE_BR = (BRANCH_NOPS > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_INSTR = 2'd2,
    S_POST  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    nop_cnt_q, nop_cnt_d;

  // held command
  logic [3:0]    mnem_q;
  logic [4:0]    rs_q, rt_q, rd_q;
  logic [15:0]   imm_q;
  logic [25:0]   tgt_q;

  // load-use tracking
  logic          pend_vld_q;
  logic [4:0]    pend_reg_q;

  logic          err_q;
  logic [15:0]   cnt_q;

  // FIFO storage
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;

  logic          accept;
  logic          legal;
  logic          rd_rs, rd_rt;
  logic          needs_pre;
  logic          is_branch;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic [31:0]   push_dat;
  logic [31:0]   enc_word;

  assign cmd_ready   = (state_q == S_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign legal       = (cmd_mnem <= M_JR);
  assign fifo_full   = (fifo_cnt_q == CW'(DEPTH));
  assign out_valid   = (fifo_cnt_q != '0);
  assign out_instr   = mem_q[rd_ptr_q];
  assign pop         = out_valid && out_ready;
  assign err_illegal = err_q;
  assign instr_count = cnt_q;
  assign is_branch   = (mnem_q == M_BEQ) || (mnem_q == M_J) ||
                       (mnem_q == M_JAL) || (mnem_q == M_JR);

  // Which source registers the incoming command reads, for the hazard check.
  always_comb begin
    rd_rs = 1'b0;
    rd_rt = 1'b0;
    case (cmd_mnem)
      M_ADDU, M_SUBU, M_SLT, M_SW, M_BEQ: begin
        rd_rs = 1'b1;
        rd_rt = 1'b1;
      end
      M_JR, M_ORI, M_LW, M_ADDI: rd_rs = 1'b1;
      default: ;
    endcase
  end

  assign needs_pre = pend_vld_q &&
                     ((rd_rs && (cmd_rs == pend_reg_q)) ||
                      (rd_rt && (cmd_rt == pend_reg_q)));

  // Encode the held command into a MIPS word.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (mnem_q)
      M_ADDU: enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100001};
      M_SUBU: enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100011};
      M_SLT:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b101010};
      M_JR:   enc_word = {6'b000000, rs_q, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      M_ORI:  enc_word = {6'b001101, rs_q, rt_q, imm_q};
      M_LW:   enc_word = {6'b100011, rs_q, rt_q, imm_q};
      M_SW:   enc_word = {6'b101011, rs_q, rt_q, imm_q};
      M_BEQ:  enc_word = {6'b000100, rs_q, rt_q, imm_q};
      M_ADDI: enc_word = {6'b001000, rs_q, rt_q, imm_q};
      M_LUI:  enc_word = {6'b001111, 5'b00000, rt_q, imm_q};
      M_J:    enc_word = {6'b000010, tgt_q};
      M_JAL:  enc_word = {6'b000011, tgt_q};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  // Sequencer: next state, NOP countdown and the FIFO push request.
  always_comb begin
    state_d   = state_q;
    nop_cnt_d = nop_cnt_q;
    push      = 1'b0;
    push_dat  = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (accept && legal) begin
          if (USE_LU && needs_pre) begin
            state_d   = S_PRE;
            nop_cnt_d = LU_N;
          end else begin
            state_d = S_INSTR;
          end
        end
      end
      S_PRE: begin
        if (!fifo_full) begin
          push      = 1'b1;
          nop_cnt_d = nop_cnt_q - 8'd1;
          if (nop_cnt_q == 8'd1) state_d = S_INSTR;
        end
      end
      S_INSTR: begin
        if (!fifo_full) begin
          push     = 1'b1;
          push_dat = enc_word;
          if (USE_BR && is_branch) begin
            state_d   = S_POST;
            nop_cnt_d = BR_N;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_POST: begin
        if (!fifo_full) begin
          push      = 1'b1;
          nop_cnt_d = nop_cnt_q - 8'd1;
          if (nop_cnt_q == 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, hold register, hazard tracking, error pulse and instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nop_cnt_q  <= 8'd0;
      mnem_q     <= 4'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rd_q       <= 5'd0;
      imm_q      <= 16'd0;
      tgt_q      <= 26'd0;
      pend_vld_q <= 1'b0;
      pend_reg_q <= 5'd0;
      err_q      <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      nop_cnt_q <= nop_cnt_d;
      err_q     <= accept && !legal;
      if (accept && legal) begin
        mnem_q     <= cmd_mnem;
        rs_q       <= cmd_rs;
        rt_q       <= cmd_rt;
        rd_q       <= cmd_rd;
        imm_q      <= cmd_imm;
        tgt_q      <= cmd_target;
        pend_vld_q <= 1'b0;
      end else if ((state_q == S_INSTR) && push && (mnem_q == M_LW) && (rt_q != 5'd0)) begin
        pend_vld_q <= 1'b1;
        pend_reg_q <= rt_q;
      end
      if ((state_q == S_INSTR) && push) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Output FIFO: push is already gated by !full, so a pop never makes room for a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0000_0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CW'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - CW'(1);
    end
  end

endmodule
